dot_prod_feeder: RTL and testbench



---
 rtl/dot_prod_feeder.sv | 139 +++++++++++++
 tb/tb_dot_prod_feeder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_prod_feeder.sv
// Feeds element pairs to the dot-product accumulator from two ping-pong vector banks,
// one vector per free-running (S+1)-cycle frame, with zeros in the gap slot and on idle frames.
module dot_prod_feeder #(
    parameter int S = 9,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [W-1:0] wr_a,
    input  logic [W-1:0] wr_b,
    input  logic         wr_last,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    output logic         frame_active,
    output logic         sum_valid,
    output logic         len_err
);

    localparam int PW = $clog2(S + 1);
    localparam int IW = (S > 1) ? $clog2(S) : 1;
    localparam logic [PW-1:0] PH_GAP   = PW'(S);
    localparam logic [PW-1:0] PH_LAST  = PW'(S - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(S - 1);

    typedef enum logic {
        FRAME_IDLE,
        FRAME_ACTIVE
    } frame_t;

    logic [PW-1:0] ph;
    logic [IW-1:0] widx;
    logic          fill_bank;
    logic [1:0]    full;
    frame_t        frame_q, frame_d;
    logic          str_q, str_d;

    logic [W-1:0]  bank_a [2][S];
    logic [W-1:0]  bank_b [2][S];

    logic accept;
    logic fill_done;

    assign wr_ready  = ~full[fill_bank];
    assign accept    = wr_valid & wr_ready;
    assign fill_done = accept & (wr_last | (widx == IDX_LAST));

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ph        <= '0;
            widx      <= '0;
            fill_bank <= 1'b0;
            full      <= 2'b00;
            sum_valid <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            ph      <= (ph == PH_GAP) ? '0 : ph + 1'b1;
            len_err <= accept & (widx == IDX_LAST) & ~wr_last;

            // The accumulator result changes at the gap edge and holds for a whole frame.
            if (ph == PH_GAP)
                sum_valid <= (frame_q == FRAME_ACTIVE);

            if (frame_q == FRAME_ACTIVE && ph == PH_LAST)
                full[str_q] <= 1'b0;

            // The fill bank is empty whenever accept is high, so it never collides with the release above.
            if (fill_done) begin
                full[fill_bank] <= 1'b1;
                widx            <= '0;
                fill_bank       <= ~fill_bank;
            end else if (accept) begin
                widx <= widx + 1'b1;
            end
        end
    end

    // NOTE: the vector banks carry no reset; the full flags gate all use of their
    // contents and every completed vector rewrites all S slots (data or zero pad).
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int j = 0; j < S; j++) begin
                if (IW'(j) == widx) begin
                    bank_a[fill_bank][j] <= wr_a;
                    bank_b[fill_bank][j] <= wr_b;
                end else if (wr_last && IW'(j) > widx) begin
                    bank_a[fill_bank][j] <= '0;
                    bank_b[fill_bank][j] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_q <= FRAME_IDLE;
            str_q   <= 1'b0;
        end else begin
            frame_q <= frame_d;
            str_q   <= str_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    // With both banks full the current fill target is the older one, since fills alternate.
    always_comb begin
        frame_d = frame_q;
        str_d   = str_q;
        if (ph == PH_GAP) begin
            if (&full) begin
                frame_d = FRAME_ACTIVE;
                str_d   = fill_bank;
            end else if (full[0]) begin
                frame_d = FRAME_ACTIVE;
                str_d   = 1'b0;
            end else if (full[1]) begin
                frame_d = FRAME_ACTIVE;
                str_d   = 1'b1;
            end else begin
                frame_d = FRAME_IDLE;
            end
        end
    end

    always_comb begin
        a            = '0;
        b            = '0;
        frame_active = 1'b0;
        if (frame_q == FRAME_ACTIVE && ph != PH_GAP) begin
            a            = bank_a[str_q][IW'(ph)];
            b            = bank_b[str_q][IW'(ph)];
            frame_active = 1'b1;
        end
    end

endmodule

// File: tb/tb_dot_prod_feeder.sv
// Directed bench for dot_prod_feeder: table of single-vector loads plus hand-written
// sequences for back-to-back banks, gap-edge completion and mid-frame reset.
module tb_dot_prod_feeder;

    localparam int S = 9;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         wr_valid;
    logic         wr_ready;
    logic [W-1:0] wr_a;
    logic [W-1:0] wr_b;
    logic         wr_last;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         frame_active;
    logic         sum_valid;
    logic         len_err;

    int total = 0;
    int bad   = 0;

    dot_prod_feeder #(.S(S), .W(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_a         (wr_a),
        .wr_b         (wr_b),
        .wr_last      (wr_last),
        .a            (a),
        .b            (b),
        .frame_active (frame_active),
        .sum_valid    (sum_valid),
        .len_err      (len_err)
    );

    always #5 clk = ~clk;

    // Accumulator counter model, released by the same reset as the feeder.
    int tb_ph;
    always @(posedge clk or negedge reset) begin
        if (!reset) tb_ph <= 0;
        else        tb_ph <= (tb_ph == S) ? 0 : tb_ph + 1;
    end

    // Accumulator model: sums a*b over the frame and dumps the total in the gap slot.
    longint acc = 0;
    longint sum_log[$];
    always @(negedge clk) begin
        if (!reset) begin
            acc = 0;
        end else if (tb_ph == S) begin
            sum_log.push_back(acc);
            acc = 0;
        end else begin
            acc += longint'(a) * longint'(b);
        end
    end

    typedef struct {
        int     n;
        bit     last;
        int     a0;
        bit     ramp;
        int     bval;
        longint exp_sum;
        bit     exp_err;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t ph=%0d)", name, act, exp, $time, tb_ph);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ph(input int p);
        int n = 0;
        while (tb_ph != p && n < 2 * (S + 1)) begin
            tick();
            n++;
        end
        if (tb_ph != p) check("wait_ph_timeout", 64'(tb_ph), 64'(p));
    endtask

    task automatic next_frame();
        tick();
        wait_ph(0);
    endtask

    // Offers elements every cycle; an element advances only when wr_ready was high.
    task automatic load(input int n, input bit last, input int a0, input bit ramp, input int bval);
        int   i     = 0;
        int   guard = 0;
        logic rdy;
        while (i < n && guard < 4 * (S + 1)) begin
            wr_valid = 1'b1;
            wr_a     = W'(ramp ? a0 + i : a0);
            wr_b     = W'(bval);
            wr_last  = last && (i == n - 1);
            rdy      = wr_ready;
            tick();
            if (rdy) i++;
            guard++;
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        if (i < n) check("load_timeout", 64'(i), 64'(n));
    endtask

    function automatic logic [63:0] outs();
        return 64'({a, b, frame_active, sum_valid, len_err, wr_ready});
    endfunction

    localparam logic [63:0] RESET_OUTS = 64'h1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int     L;
        longint ea, eb;

        tbl[0] = '{n: 9, last: 1'b1, a0: 1,   ramp: 1'b1, bval: 1,   exp_sum: 45,    exp_err: 1'b0};
        tbl[1] = '{n: 4, last: 1'b1, a0: 10,  ramp: 1'b0, bval: 10,  exp_sum: 400,   exp_err: 1'b0};
        tbl[2] = '{n: 9, last: 1'b0, a0: 3,   ramp: 1'b0, bval: 7,   exp_sum: 189,   exp_err: 1'b1};
        tbl[3] = '{n: 1, last: 1'b1, a0: 255, ramp: 1'b0, bval: 255, exp_sum: 65025, exp_err: 1'b0};
        tbl[4] = '{n: 9, last: 1'b1, a0: 200, ramp: 1'b1, bval: 2,   exp_sum: 3672,  exp_err: 1'b0};

        reset    = 1'b0;
        wr_valid = 1'b0;
        wr_a     = '0;
        wr_b     = '0;
        wr_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", outs(), RESET_OUTS);
        @(negedge clk);
        reset = 1'b1;

        // Three idle frames with no writes.
        for (int c = 0; c < 3 * (S + 1); c++) begin
            tick();
            check("idle_outs", outs(), RESET_OUTS);
        end

        // Single-vector table.
        wait_ph(0);
        for (int t = 0; t < 5; t++) begin
            check("sv_low_after_idle", 64'(sum_valid), 64'(0));
            load(tbl[t].n, tbl[t].last, tbl[t].a0, tbl[t].ramp, tbl[t].bval);
            check("len_err", 64'(len_err), 64'(tbl[t].exp_err));
            tick();
            check("len_err_pulse_end", 64'(len_err), 64'(0));
            wait_ph(0);
            for (int k = 0; k <= S; k++) begin
                ea = (k < tbl[t].n) ? (tbl[t].ramp ? tbl[t].a0 + k : tbl[t].a0) : 0;
                eb = (k < tbl[t].n) ? tbl[t].bval : 0;
                check("stream_a", 64'(a), 64'(ea));
                check("stream_b", 64'(b), 64'(eb));
                check("stream_fa", 64'(frame_active), 64'(k < S));
                if (k == 0) check("sv_in_stream", 64'(sum_valid), 64'(0));
                tick();
            end
            check("vec_sum", 64'(sum_log[$]), 64'(tbl[t].exp_sum));
            for (int k = 0; k <= S; k++) begin
                check("sv_hold", 64'({sum_valid, frame_active}), 64'b10);
                tick();
            end
        end

        // Back-to-back banks, with a third vector that must stall.
        wait_ph(0);
        L = sum_log.size();
        load(S, 1'b1, 2, 1'b0, 3);
        load(S, 1'b1, 255, 1'b0, 255);
        check("b2b_ready_low", 64'(wr_ready), 64'(0));
        load(S, 1'b1, 1, 1'b1, 1);
        for (int f = 0; f < 4; f++) next_frame();
        check("b2b_log_size", 64'(sum_log.size() >= L + 4), 64'(1));
        check("b2b_idle", 64'(sum_log[L]), 64'(0));
        check("b2b_v1", 64'(sum_log[L + 1]), 64'(54));
        check("b2b_v2", 64'(sum_log[L + 2]), 64'(585225));
        check("b2b_v3", 64'(sum_log[L + 3]), 64'(45));

        // Bank completing on the gap edge streams one frame later.
        next_frame();
        wait_ph(1);
        L = sum_log.size();
        load(S, 1'b1, 4, 1'b0, 5);
        check("gap_not_immediate", 64'(frame_active), 64'(0));
        next_frame();
        check("gap_streams_later", 64'({frame_active, a}), 64'({1'b1, 8'd4}));
        next_frame();
        check("gap_log_size", 64'(sum_log.size() >= L + 3), 64'(1));
        check("gap_idle_frame", 64'(sum_log[L + 1]), 64'(0));
        check("gap_sum", 64'(sum_log[L + 2]), 64'(180));

        // Reset at ph=5 of an active frame with the other bank half-loaded.
        next_frame();
        load(S, 1'b1, 1, 1'b0, 1);
        tick();
        check("rst_pre_ph0", 64'(tb_ph), 64'(0));
        load(4, 1'b0, 3, 1'b0, 3);
        tick();
        check("rst_pre_active", 64'({frame_active, a}), 64'({1'b1, 8'd1}));
        reset = 1'b0;
        #1;
        check("rst_immediate", outs(), RESET_OUTS);
        repeat (3) @(posedge clk);
        #1;
        check("rst_held", outs(), RESET_OUTS);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 2 * (S + 1); c++) begin
            tick();
            check("post_rst_idle", outs(), RESET_OUTS);
        end
        wait_ph(0);
        L = sum_log.size();
        load(S, 1'b1, 1, 1'b1, 1);
        next_frame();
        next_frame();
        check("post_rst_log_size", 64'(sum_log.size() >= L + 2), 64'(1));
        check("post_rst_sum", 64'(sum_log[L + 1]), 64'(45));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
